// File: rtl/uart_rx_core_if.sv
// Received-word handshake between the UART receiver (master) and its consumer (slave).
// out/parity_err/frame_err are meaningful only while out_valid is high.
interface uart_rx_core_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] out;
   logic                 out_valid;
   logic                 out_ready;
   logic                 parity_err;
   logic                 frame_err;

   modport master (
      output out, out_valid, parity_err, frame_err,
      input  out_ready
   );

   modport slave (
      input  out, out_valid, parity_err, frame_err,
      output out_ready
   );
endinterface

// File: rtl/uart_rx_core.sv
// Mid-bit-sampling UART receiver; word valid 2+HALF+DIV*NB cycles after the start edge is captured.
// A frame completing while the held word is unaccepted is dropped and flagged by a one-cycle overrun pulse.
module uart_rx_core #(
   parameter int CLK_FREQ  = 125000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rx_in,
   uart_rx_core_if.master m,
   output logic           overrun,
   output logic           busy
);
   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);
   localparam int IW   = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, rx_s_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] out_q, out_d;
   logic                 pe_q, pe_d;
   logic                 fe_q, fe_d;
   logic                 out_valid_q, out_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
   logic                 fe_now;
   logic                 at_half;
   logic                 at_div;

   assign at_half = (cnt_q == CW'(HALF - 1));
   assign at_div  = (cnt_q == CW'(DIV - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = (state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
      idx_d        = idx_q;
      shift_d      = shift_q;
      pe_d         = pe_q;
      fe_d         = fe_q;
      out_d        = out_q;
      out_valid_d  = out_valid_q & ~m.out_ready;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      overrun_d    = 1'b0;
      fe_now       = fe_q | ~rx_s_q;

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (at_half) begin
               cnt_d = '0;
               idx_d = '0;
               pe_d  = 1'b0;
               fe_d  = 1'b0;
               // A line already back high at mid-start-bit was only a glitch.
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (at_div) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               if (idx_q == IW'(DATA_BITS - 1)) begin
                  idx_d   = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_PARITY: begin
            if (at_div) begin
               cnt_d   = '0;
               pe_d    = (PARITY == 1) ? ~(^shift_q ^ rx_s_q) : (^shift_q ^ rx_s_q);
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (at_div) begin
               cnt_d = '0;
               fe_d  = fe_now;
               if (idx_q == IW'(STOP_BITS - 1)) begin
                  // A low last stop bit parks in BREAK so a held-low line reports once.
                  state_d = rx_s_q ? S_IDLE : S_BREAK;
                  if (!out_valid_q || m.out_ready) begin
                     out_d        = shift_q;
                     parity_err_d = pe_q;
                     frame_err_d  = fe_now;
                     out_valid_d  = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_BREAK: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         pe_q         <= 1'b0;
         fe_q         <= 1'b0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync1_q      <= rx_in;
         rx_s_q       <= sync1_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         pe_q         <= pe_d;
         fe_q         <= fe_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign m.out        = out_q;
   assign m.out_valid  = out_valid_q;
   assign m.parity_err = parity_err_q;
   assign m.frame_err  = frame_err_q;
   assign overrun      = overrun_q;
   assign busy         = (state_q != S_IDLE);
endmodule
